// File: rtl/clock_display_driver_pkg.sv
// rtl/clock_display_driver_pkg.sv - shared types and seven-segment codes for the MM:SS display driver
package clock_disp_pkg;

    typedef enum logic [1:0] {S0, S1, S2, S3} digit_idx_t;

    // Active-high codes ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_DASH;
    endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// rtl/bin2bcd_60.sv - splits a 0..59 time field into tens/ones digits, flags values above 59
module bin2bcd_60 (
    input  logic [5:0] value,
    output logic [2:0] tens,
    output logic [3:0] ones,
    output logic       invalid
);

    always_comb begin
        tens = 3'd0;
        ones = value[3:0];
        if (value >= 6'd50) begin
            tens = 3'd5;
            ones = 4'(value - 6'd50);
        end else if (value >= 6'd40) begin
            tens = 3'd4;
            ones = 4'(value - 6'd40);
        end else if (value >= 6'd30) begin
            tens = 3'd3;
            ones = 4'(value - 6'd30);
        end else if (value >= 6'd20) begin
            tens = 3'd2;
            ones = 4'(value - 6'd20);
        end else if (value >= 6'd10) begin
            tens = 3'd1;
            ones = 4'(value - 6'd10);
        end
        invalid = (value > 6'd59);
    end

endmodule

// File: rtl/clock_display_driver.sv
// rtl/clock_display_driver.sv - snapshots MM:SS and scans it onto a 4-digit multiplexed seven-segment display
import clock_disp_pkg::*;

module clock_display_driver #(
    parameter int SCAN_DIV     = 1000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] dig,
    output logic       dp
);

    localparam int             PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre;
    digit_idx_t       idx;
    logic [5:0]       min_q, sec_q;
    logic             blank_q;
    logic [6:0]       seg_r;
    logic [3:0]       dig_r;
    logic             dp_r;

    logic [2:0] sec_tens, min_tens;
    logic [3:0] sec_ones, min_ones;
    logic       sec_inv, min_inv;
    logic [6:0] slot_seg;
    logic       active;

    bin2bcd_60 u_sec_bcd (.value(sec_q), .tens(sec_tens), .ones(sec_ones), .invalid(sec_inv));
    bin2bcd_60 u_min_bcd (.value(min_q), .tens(min_tens), .ones(min_ones), .invalid(min_inv));

    // Prescaler 0 is the dead-time cycle of every slot
    assign active = (pre != '0) && !blank_q;

    always_comb begin
        slot_seg = SEG_OFF;
        case (idx)
            S0: slot_seg = sec_inv ? SEG_DASH : seg_encode(sec_ones);
            S1: slot_seg = sec_inv ? SEG_DASH : seg_encode({1'b0, sec_tens});
            S2: slot_seg = min_inv ? SEG_DASH : seg_encode(min_ones);
            S3: slot_seg = min_inv ? SEG_DASH : seg_encode({1'b0, min_tens});
            default: slot_seg = SEG_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= S0;
            min_q   <= '0;
            sec_q   <= '0;
            blank_q <= 1'b0;
            seg_r   <= SEG_OFF;
            dig_r   <= 4'b0000;
            dp_r    <= 1'b0;
        end else begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= digit_idx_t'(idx + 2'd1);
            end else begin
                pre <= pre + 1'b1;
            end
            if (load) begin
                min_q <= min;
                sec_q <= sec;
            end
            blank_q <= blank;
            seg_r   <= active ? slot_seg : SEG_OFF;
            dig_r   <= active ? (4'b0001 << idx) : 4'b0000;
            dp_r    <= active && (idx == S2) && !sec_q[0];
        end
    end

    assign seg = seg_r ^ {7{COMMON_ANODE}};
    assign dig = dig_r ^ {4{COMMON_ANODE}};
    assign dp  = dp_r ^ COMMON_ANODE;

endmodule
